// File: rtl/addern_pipe.sv
// addern_pipe: pipelined two's-complement adder with a valid/ready handshake on both sides.
// The operands are split into CHUNK-bit slices and each pipeline stage adds one slice.
// The carry is registered between stages. The final stage adds the top slice, detects
// signed overflow, and optionally saturates the sum. A sticky overflow flag collects
// overflow over all delivered results.
module addern_pipe #(
  parameter int WIDTH    = 16,
  parameter int CHUNK    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;
  localparam int MSB    = WIDTH - 1;

  // Per-stage registers. Index k holds the beat after slice k has been added.
  logic [STAGES-1:0]            v_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_q;
  logic [STAGES-1:0][WIDTH-1:0] s_q;
  logic [STAGES-1:0]            c_q;
  logic                         ovf_q;

  // Per-stage inputs: stage 0 takes the ports, stage k takes the registers of stage k-1.
  logic [STAGES-1:0]            src_v;
  logic [STAGES-1:0][WIDTH-1:0] src_a;
  logic [STAGES-1:0][WIDTH-1:0] src_b;
  logic [STAGES-1:0][WIDTH-1:0] src_s;
  logic [STAGES-1:0]            src_c;
  logic [STAGES-1:0][CHUNK:0]   slice_sum;
  logic [STAGES-1:0][WIDTH-1:0] raw_s;
  logic [STAGES-1:0]            carry_out;

  logic             advance;
  logic             carry_msb;
  logic             ovf_d;
  logic [WIDTH-1:0] sat_val;
  logic [WIDTH-1:0] fin_s;

  // Every stage moves at once. A stall happens only while a finished result waits downstream.
  assign advance  = !v_q[LAST] | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_src
      assign src_v[k] = in_valid;
      assign src_a[k] = a;
      assign src_b[k] = b;
      assign src_s[k] = '0;
      assign src_c[k] = cin;
    end else begin : g_src
      assign src_v[k] = v_q[k-1];
      assign src_a[k] = a_q[k-1];
      assign src_b[k] = b_q[k-1];
      assign src_s[k] = s_q[k-1];
      assign src_c[k] = c_q[k-1];
    end

    assign slice_sum[k] = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                        + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                        + (CHUNK+1)'(src_c[k]);
    // Slices above k are still zero in the partial sum, so OR-ing in the new slice is exact.
    assign raw_s[k]     = src_s[k] | (WIDTH'(slice_sum[k][CHUNK-1:0]) << (k*CHUNK));
    assign carry_out[k] = slice_sum[k][CHUNK];
  end

  // Signed overflow: the carry into the MSB is recovered from the MSB sum bit.
  assign carry_msb = src_a[LAST][MSB] ^ src_b[LAST][MSB] ^ raw_s[LAST][MSB];
  assign ovf_d     = carry_msb ^ carry_out[LAST];
  assign sat_val   = src_a[LAST][MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign fin_s     = (SATURATE && ovf_d) ? sat_val : raw_s[LAST];

  // Pipeline registers: shift together on advance and hold both bubbles and data on a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      v_q       <= src_v;
      a_q       <= src_a;
      b_q       <= src_b;
      s_q       <= raw_s;
      s_q[LAST] <= fin_s;
      c_q       <= carry_out;
      ovf_q     <= ovf_d;
    end
  end

  // Sticky overflow: a delivered overflow takes priority over a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_sticky <= 1'b0;
    else if (v_q[LAST] && out_ready && ovf_q)
      ovf_sticky <= 1'b1;
    else if (ovf_clr)
      ovf_sticky <= 1'b0;
  end

  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  assign overflow  = ovf_q;

  // The last stage's operand copies have no consumer.
  logic unused_last_ops;
  assign unused_last_ops = ^{a_q[LAST], b_q[LAST]};

endmodule
